// File: rtl/m0.sv
// m0: pipelined add/XOR mixing datapath, STAGES deep, WIDTH wide.
// Ports: clk, rst (async high), in_0/in_1 operands, out_0 = last x reg.
module m0 #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_0,
  input  logic [WIDTH-1:0] in_1,
  output logic [WIDTH-1:0] out_0
);

  // x[k]/y[k] hold stage k+1; stage 0 is the raw operand pair.
  logic [WIDTH-1:0] x [STAGES];
  logic [WIDTH-1:0] y [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        x[k] <= '0;
        y[k] <= '0;
      end
    end else begin
      // carry-out dropped by truncation to WIDTH
      x[0] <= in_0 + in_1;
      y[0] <= in_0 ^ in_1;
      for (int k = 1; k < STAGES; k++) begin
        x[k] <= x[k-1] + y[k-1];
        y[k] <= x[k-1] ^ y[k-1];
      end
    end
  end

  assign out_0 = x[STAGES-1];

endmodule

// File: tb/tb_m0.sv
// tb_m0: directed checks of m0 (default, STAGES=1, WIDTH=8).
// Expected values are hand-derived stage traces.
module tb_m0;

  logic       clk;
  logic       rst;
  logic [4:0] in_0;
  logic [4:0] in_1;
  logic [4:0] out_0;
  logic [4:0] s_in_0;
  logic [4:0] s_in_1;
  logic [4:0] s_out;
  logic [7:0] w_in_0;
  logic [7:0] w_in_1;
  logic [7:0] w_out;

  int errors;
  int checks;

  m0 dut (
    .clk  (clk),
    .rst  (rst),
    .in_0 (in_0),
    .in_1 (in_1),
    .out_0(out_0)
  );

  m0 #(.WIDTH(5), .STAGES(1)) dut_s1 (
    .clk  (clk),
    .rst  (rst),
    .in_0 (s_in_0),
    .in_1 (s_in_1),
    .out_0(s_out)
  );

  m0 #(.WIDTH(8), .STAGES(4)) dut_w8 (
    .clk  (clk),
    .rst  (rst),
    .in_0 (w_in_0),
    .in_1 (w_in_1),
    .out_0(w_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_0 = 5'h0F;
    in_1 = 5'h0F;
    #2;
    checks++;
    if (out_0 !== 5'h00) begin
      errors++;
      $display("FAIL reset_init got %h want 00", out_0);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) tick();
    checks++;
    if (out_0 !== 5'h1C) begin
      errors++;
      $display("FAIL reset_prefill got %h want 1c", out_0);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_0 !== 5'h00) begin
      errors++;
      $display("FAIL reset_async got %h want 00", out_0);
    end
    in_0 = 5'h00;
    in_1 = 5'h00;
    tick();
    checks++;
    if (out_0 !== 5'h00) begin
      errors++;
      $display("FAIL reset_held got %h want 00", out_0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (out_0 !== 5'h00) begin
        errors++;
        $display("FAIL reset_refill_%0d got %h want 00", i, out_0);
      end
    end
  endtask

  task automatic test_single();
    logic [4:0] exp;
    in_0 = 5'h01;
    in_1 = 5'h00;
    tick();
    in_0 = 5'h00;
    for (int e = 1; e <= 6; e++) begin
      if (e > 1) tick();
      exp = (e == 4) ? 5'h04 : 5'h00;
      checks++;
      if (out_0 !== exp) begin
        errors++;
        $display("FAIL single_e%0d got %h want %h", e, out_0, exp);
      end
    end
  endtask

  task automatic test_equal();
    logic [4:0] exp;
    in_0 = 5'h0F;
    in_1 = 5'h0F;
    for (int e = 1; e <= 6; e++) begin
      tick();
      exp = (e >= 4) ? 5'h1C : 5'h00;
      checks++;
      if (out_0 !== exp) begin
        errors++;
        $display("FAIL equal_e%0d got %h want %h", e, out_0, exp);
      end
    end
  endtask

  task automatic test_streaming();
    logic [4:0] exp;
    for (int i = 1; i <= 10; i++) begin
      in_0 = i[0] ? 5'h0F : 5'h00;
      in_1 = i[0] ? 5'h0F : 5'h00;
      tick();
      if (i >= 4) begin
        exp = ((i - 3) % 2 == 1) ? 5'h1C : 5'h00;
        checks++;
        if (out_0 !== exp) begin
          errors++;
          $display("FAIL stream_e%0d got %h want %h", i, out_0, exp);
        end
      end
    end
    in_0 = 5'h00;
    in_1 = 5'h00;
    repeat (4) tick();
  endtask

  task automatic test_wrap();
    in_0 = 5'h1F;
    in_1 = 5'h01;
    tick();
    in_0 = 5'h00;
    in_1 = 5'h00;
    checks++;
    if (dut.x[0] !== 5'h00 || dut.y[0] !== 5'h1E) begin
      errors++;
      $display("FAIL wrap_stage1 got %h/%h want 00/1e",
               dut.x[0], dut.y[0]);
    end
    repeat (3) tick();
    checks++;
    if (out_0 !== 5'h1C) begin
      errors++;
      $display("FAIL wrap_out got %h want 1c", out_0);
    end
    tick();
    checks++;
    if (out_0 !== 5'h00) begin
      errors++;
      $display("FAIL wrap_after got %h want 00", out_0);
    end
  endtask

  task automatic test_params();
    s_in_0 = 5'd3;
    s_in_1 = 5'd4;
    w_in_0 = 8'hFF;
    w_in_1 = 8'hFF;
    tick();
    s_in_0 = 5'd0;
    s_in_1 = 5'd0;
    w_in_0 = 8'h00;
    w_in_1 = 8'h00;
    checks++;
    if (s_out !== 5'd7) begin
      errors++;
      $display("FAIL s1_out got %h want 07", s_out);
    end
    checks++;
    if (w_out !== 8'h00) begin
      errors++;
      $display("FAIL w8_early got %h want 00", w_out);
    end
    tick();
    checks++;
    if (s_out !== 5'd0) begin
      errors++;
      $display("FAIL s1_after got %h want 00", s_out);
    end
    repeat (2) tick();
    checks++;
    if (w_out !== 8'hFC) begin
      errors++;
      $display("FAIL w8_out got %h want fc", w_out);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    s_in_0 = '0;
    s_in_1 = '0;
    w_in_0 = '0;
    w_in_1 = '0;
    test_reset();
    test_single();
    test_equal();
    test_streaming();
    test_wrap();
    test_params();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
